// File: rtl/convenc_drain_if.sv
// -----------------------------------------------------------------------------
// convenc_drain_if
//   Byte stream from the convolutional-encoder drain to the rate-matching stage.
//   A byte moves on any rising clock edge where out_valid and out_ready are both 1.
//
//   Signals
//     out_data  [7:0]  interleaved coded byte       (master -> slave)
//     out_valid        out_data holds a byte        (master -> slave)
//     out_ready        downstream takes the byte    (slave  -> master)
//
//   Modports
//     master : the drain (drives data/valid, reads ready)
//     slave  : the downstream consumer
// -----------------------------------------------------------------------------
interface convenc_drain_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/convenc_drain.sv
// -----------------------------------------------------------------------------
// convenc_drain
//   Reads the three subblock FIFOs of the convolutional encoder in lockstep,
//   one byte per stream, and bit-interleaves the 24 coded bits as
//   e[3i+s] = q_s[i]. The result goes out as three bytes e[7:0], e[15:8],
//   e[23:16] on a valid/ready stream. Groups of three bytes are counted
//   against the block length chosen at start; blk_done marks the end.
//
//   Parameters
//     K_SMALL  small block length in info bits (multiple of 8)
//     K_LARGE  large block length in info bits (multiple of 8)
//     TIMEOUT  stall-cycle limit of the watchdog
//
//   Optional feature
//     CONVDRAIN_WDOG_EN : when defined, a stall watchdog aborts the block
//                         after TIMEOUT consecutive stall cycles and pulses
//                         err_timeout. When undefined, err_timeout is tied 0
//                         and stalls are unbounded.
//
//   Ports
//     clk             clock
//     reset           synchronous, active-high reset
//     start           one-cycle pulse, begin a block (ignored when busy)
//     size_sel        sampled with start: 1 = K_LARGE, 0 = K_SMALL
//     empty[2:0]      FIFO empty flags, bit s = stream s
//     q0, q1, q2      FIFO read data (non-show-ahead), bit 0 = oldest bit
//     rdreq_subblock  FIFO read requests, always 3'b000 or 3'b111
//     strm            output byte stream (convenc_drain_if.master)
//     busy            high from the cycle after an accepted start to IDLE
//     blk_done        one-cycle pulse, last byte of block accepted
//     err_timeout     one-cycle pulse, block aborted by the watchdog
// -----------------------------------------------------------------------------
module convenc_drain #(
  parameter int unsigned K_SMALL = 1056,
  parameter int unsigned K_LARGE = 6144,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   size_sel,
  input  logic [2:0]             empty,
  input  logic [7:0]             q0,
  input  logic [7:0]             q1,
  input  logic [7:0]             q2,
  output logic [2:0]             rdreq_subblock,
  convenc_drain_if.master        strm,
  output logic                   busy,
  output logic                   blk_done,
  output logic                   err_timeout
);

  // Groups of 8 info bits per block; 768 groups for K = 6144 fit 10 bits.
  localparam logic [9:0] GRP_SMALL = 10'(K_SMALL / 8);
  localparam logic [9:0] GRP_LARGE = 10'(K_LARGE / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_LOAD,
    S_EMIT0,
    S_EMIT1,
    S_EMIT2,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [9:0]  r_grp_cnt;
  logic [9:0]  r_grp_total;
  logic [23:0] r_e;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_busy;
  logic        r_blk_done;
  logic        r_err_timeout;

  logic [23:0] w_e;
  logic [9:0]  w_grp_next;
  logic        w_in_emit;
  logic        w_wdog_fire;

  // Bit interleave of the three stream bytes: e[3i+s] = q_s[i].
  always_comb begin
    w_e = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_e[3*i]     = q0[i];
      w_e[3*i + 1] = q1[i];
      w_e[3*i + 2] = q2[i];
    end
  end

  assign w_grp_next = r_grp_cnt + 10'd1;
  assign w_in_emit  = (r_state == S_EMIT0) || (r_state == S_EMIT1) ||
                      (r_state == S_EMIT2);

`ifdef CONVDRAIN_WDOG_EN
  logic [15:0] r_stall;
  logic        w_stalled;

  // A non-stalled WAIT/EMIT cycle always leaves its state, and no other state
  // ever stalls, so "clear when not stalled" equals "clear on state change".
  assign w_stalled   = ((r_state == S_WAIT) && (empty != 3'b000)) ||
                       (w_in_emit && !strm.out_ready);
  // Fires on the TIMEOUT-th consecutive stall cycle; err_timeout is
  // registered and therefore visible in the following (IDLE) cycle.
  assign w_wdog_fire = w_stalled && (r_stall == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
    end else if (w_stalled && !w_wdog_fire) begin
      r_stall <= r_stall + 16'd1;
    end else begin
      r_stall <= '0;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0) & w_in_emit;
  assign w_wdog_fire      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_grp_cnt     <= '0;
      r_grp_total   <= '0;
      r_e           <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_blk_done    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_blk_done    <= 1'b0;
      r_err_timeout <= 1'b0;

      if (w_wdog_fire) begin
        r_state       <= S_IDLE;
        r_out_valid   <= 1'b0;
        r_busy        <= 1'b0;
        r_err_timeout <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              r_grp_total <= size_sel ? GRP_LARGE : GRP_SMALL;
              r_grp_cnt   <= '0;
              r_busy      <= 1'b1;
              r_state     <= S_WAIT;
            end
          end

          // Only proceed when all three streams hold data; no stream is
          // ever read on its own.
          S_WAIT: begin
            if (empty == 3'b000) begin
              r_state <= S_READ;
            end
          end

          S_READ: r_state <= S_LOAD;

          // FIFO data is valid now (one cycle after rdreq). The first byte is
          // registered straight from the interleave so EMIT0 presents it.
          S_LOAD: begin
            r_e         <= w_e;
            r_out_data  <= w_e[7:0];
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT0;
          end

          S_EMIT0: begin
            if (strm.out_ready) begin
              r_out_data <= r_e[15:8];
              r_state    <= S_EMIT1;
            end
          end

          S_EMIT1: begin
            if (strm.out_ready) begin
              r_out_data <= r_e[23:16];
              r_state    <= S_EMIT2;
            end
          end

          S_EMIT2: begin
            if (strm.out_ready) begin
              r_out_valid <= 1'b0;
              r_grp_cnt   <= w_grp_next;
              if (w_grp_next == r_grp_total) begin
                r_blk_done <= 1'b1;
                r_state    <= S_DONE;
              end else begin
                r_state    <= S_WAIT;
              end
            end
          end

          // start arriving here is deliberately dropped.
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rdreq_subblock = (r_state == S_READ) ? 3'b111 : 3'b000;
  assign strm.out_data  = r_out_data;
  assign strm.out_valid = r_out_valid;
  assign busy           = r_busy;
  assign blk_done       = r_blk_done;
  assign err_timeout    = r_err_timeout;

endmodule

// File: tb/tb_convenc_drain.sv
module tb_convenc_drain;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       size_sel;
  logic [2:0] empty;
  logic [7:0] q0, q1, q2;
  logic [2:0] rdreq_subblock;
  logic       busy;
  logic       blk_done;
  logic       err_timeout;

  convenc_drain_if strm_if ();

  convenc_drain #(
    .K_SMALL (1056),
    .K_LARGE (6144),
    .TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .size_sel       (size_sel),
    .empty          (empty),
    .q0             (q0),
    .q1             (q1),
    .q2             (q2),
    .rdreq_subblock (rdreq_subblock),
    .strm           (strm_if),
    .busy           (busy),
    .blk_done       (blk_done),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Source pattern per stream; mode 0: q0=FF others 00, mode 1: all FF,
  // otherwise a group-dependent mix.
  function automatic logic [7:0] pat(input int m, input int g, input int s);
    case (m)
      0:       return (s == 0) ? 8'hFF : 8'h00;
      1:       return 8'hFF;
      default: return 8'((g * 29 + s * 71 + 13) ^ (g >> 2));
    endcase
  endfunction

  // Output byte j, bit k carries coded bit n = 8j+k = 3i+s, i.e. q_s[i].
  function automatic logic [7:0] model_byte(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input int j);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) begin
      int n;
      int i;
      int s;
      n = 8 * j + k;
      i = n / 3;
      s = n % 3;
      r[k] = (s == 0) ? a[i] : ((s == 1) ? b[i] : c[i]);
    end
    return r;
  endfunction

  logic [7:0] pat0_exp [3] = '{8'h49, 8'h92, 8'h24};

  int         mode = 0;
  bit         bp_en = 0;
  bit         rd_pend = 0;
  int         grp = 0;
  logic [7:0] exp_q [$];
  int         rd_pulses = 0;
  int         bytes_acc = 0;
  int         first_valid = -1;
  bit         hold_pend = 0;
  logic [7:0] hold_data;
  logic [7:0] mon_e;

  // FIFO model, downstream sink and output scoreboard, all on the falling edge.
  always @(negedge clk) begin
    if (rd_pend) begin
      q0 = pat(mode, grp, 0);
      q1 = pat(mode, grp, 1);
      q2 = pat(mode, grp, 2);
      for (int j = 0; j < 3; j++) exp_q.push_back(model_byte(q0, q1, q2, j));
      grp++;
    end
    rd_pend = (rdreq_subblock == 3'b111);
    if (rd_pend) rd_pulses++;

    if (hold_pend)
      check("hold", 32'({strm_if.out_valid, strm_if.out_data}), 32'({1'b1, hold_data}));

    strm_if.out_ready = bp_en ? ~strm_if.out_ready : 1'b1;
    hold_pend = strm_if.out_valid && !strm_if.out_ready && !reset;
    hold_data = strm_if.out_data;

    if (strm_if.out_valid && first_valid < 0) first_valid = cyc;

    if (strm_if.out_valid && strm_if.out_ready && !reset) begin
      if (exp_q.size() == 0) begin
        check("extra_byte", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("byte", 32'(strm_if.out_data), 32'(mon_e));
      end
      if (mode == 0) check("pat0_byte", 32'(strm_if.out_data), 32'(pat0_exp[bytes_acc % 3]));
      if (mode == 1) check("ones_byte", 32'(strm_if.out_data), 32'h0000_00FF);
      bytes_acc++;
    end
  end

  task automatic clear_model();
    grp = 0;
    exp_q.delete();
    rd_pulses = 0;
    bytes_acc = 0;
    first_valid = -1;
    rd_pend = 0;
    hold_pend = 0;
  endtask

  task automatic run_block(input bit sel, input int m, input bit bp, input bit stall, input bit poke);
    int  c0;
    int  k;
    int  groups;
    int  done_at;
    int  stall_rd;
    bit  seen;
    groups = sel ? 768 : 132;
    @(negedge clk); #1;
    clear_model();
    mode = m;
    bp_en = bp;
    start = 1'b1;
    size_sel = sel;
    c0 = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    size_sel = ~sel;
    check("busy_after_start", 32'(busy), 32'd1);
    seen = 0;
    stall_rd = 0;
    done_at = 0;
    for (int t = 0; t < 20000 && !seen; t++) begin
      k = cyc - c0;
      empty = (stall && k >= 300 && k < 320) ? 3'b010 : 3'b000;
      if (stall && k >= 301 && k <= 320 && rdreq_subblock != 3'b000) stall_rd++;
      start = poke && (k == 100);
      if (blk_done) begin
        seen = 1;
        done_at = cyc;
      end else begin
        @(negedge clk); #1;
      end
    end
    start = 1'b0;
    check("blk_done_seen", 32'(seen), 32'd1);
    if (!bp && !stall) check("block_len", 32'(done_at - c0 + 1), 32'(groups * 6 + 2));
    check("first_valid_lat", 32'(first_valid - c0), 32'd4);
    check("rd_pulses", 32'(rd_pulses), 32'(groups));
    check("bytes", 32'(bytes_acc), 32'(groups * 3));
    check("exp_left", 32'(exp_q.size()), 32'd0);
    if (stall) check("stall_rdreq", 32'(stall_rd), 32'd0);
    check("busy_in_done", 32'(busy), 32'd1);
    // start during DONE must be dropped
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("busy_idle", 32'(busy), 32'd0);
    check("blk_done_pulse", 32'(blk_done), 32'd0);
    @(negedge clk); #1;
    check("start_in_done_ignored", 32'(busy), 32'd0);
  endtask

  task automatic reset_mid_block();
    @(negedge clk); #1;
    clear_model();
    mode = 2;
    bp_en = 0;
    start = 1'b1;
    size_sel = 1'b0;
    @(negedge clk); #1;
    start = 1'b0;
    // 16 bytes counted: the cycle is EMIT0 of group 5, next one is EMIT1
    for (int t = 0; t < 500 && bytes_acc != 16; t++) begin
      @(negedge clk); #1;
    end
    check("reach_group5", 32'(bytes_acc), 32'd16);
    @(negedge clk); #1;
    check("emit1_valid", 32'(strm_if.out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk); #1;
    check("reset_outputs", 32'({rdreq_subblock, strm_if.out_data, strm_if.out_valid,
                                busy, blk_done, err_timeout}), 32'd0);
    reset = 1'b0;
    clear_model();
  endtask

`ifdef CONVDRAIN_WDOG_EN
  task automatic watchdog_test();
    int c0;
    int at;
    int bd;
    bit seen;
    @(negedge clk); #1;
    clear_model();
    empty = 3'b001;
    start = 1'b1;
    size_sel = 1'b0;
    c0 = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    seen = 0;
    at = 0;
    bd = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (blk_done) bd++;
      if (err_timeout) begin
        seen = 1;
        at = cyc;
      end else begin
        @(negedge clk); #1;
      end
    end
    check("wdog_fired", 32'(seen), 32'd1);
    check("wdog_latency", 32'(at - c0), 32'd17);
    check("wdog_busy", 32'(busy), 32'd0);
    check("wdog_no_done", 32'(bd), 32'd0);
    check("wdog_rdreq", 32'(rd_pulses), 32'd0);
    empty = 3'b000;
    @(negedge clk); #1;
    check("wdog_pulse_len", 32'(err_timeout), 32'd0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    size_sel = 1'b0;
    empty = 3'b000;
    q0 = '0;
    q1 = '0;
    q2 = '0;
    strm_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_values", 32'({rdreq_subblock, strm_if.out_data, strm_if.out_valid,
                               busy, blk_done, err_timeout}), 32'd0);
    reset = 1'b0;

    run_block(1'b0, 0, 1'b0, 1'b0, 1'b0);   // small, FF/00/00 pattern
    run_block(1'b1, 1, 1'b0, 1'b0, 1'b0);   // large, all ones
    run_block(1'b0, 2, 1'b1, 1'b0, 1'b1);   // backpressure + start while busy
    run_block(1'b0, 2, 1'b0, 1'b1, 1'b0);   // partial empty stall
    reset_mid_block();
    run_block(1'b0, 2, 1'b0, 1'b0, 1'b0);   // fresh block after reset
`ifdef CONVDRAIN_WDOG_EN
    watchdog_test();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/convenc_drain.md
# convenc_drain

Reader for the convolutional encoder's three subblock output FIFOs. Pops one byte from each stream (d0, d1, d2) in lockstep and bit-interleaves the 24 coded bits into three output bytes (d0[i], d1[i], d2[i] order). Presents them on a valid/ready byte stream to the downstream rate-matching stage. Counts groups against the active block length and signals end of block.

## Interface
Parameters:
- K_SMALL, 1056, small block length in info bits; must be a multiple of 8
- K_LARGE, 6144, large block length in info bits; must be a multiple of 8
- TIMEOUT, 1024, stall-cycle limit for the watchdog (CONVDRAIN_WDOG_EN only)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begin draining one block (ignored when busy=1)
- size_sel  in  1  sampled with start; 1 = K_LARGE, 0 = K_SMALL
- empty  in  3  empty flags of subblock FIFOs, bit s = stream s
- q0, q1, q2  in  8 each  FIFO read data; bit 0 = oldest coded bit
- rdreq_subblock  out  3  FIFO read requests, always driven as 3'b000 or 3'b111
- out_data  out  8  interleaved coded byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- busy  out  1  high from the cycle after accepted start until return to IDLE
- blk_done  out  1  one-cycle pulse, last byte of block accepted
- err_timeout  out  1  one-cycle pulse, block aborted by watchdog (tied 0 without macro)

## Operation
- States: IDLE, WAIT, READ, LOAD, EMIT0, EMIT1, EMIT2, DONE.
- IDLE: on start, latch groups_total = (size_sel ? K_LARGE : K_SMALL)/8, clear group counter (10 bits, max 768), go WAIT.
- WAIT: when empty == 3'b000, go READ; otherwise stay.
- READ: rdreq_subblock = 3'b111 for exactly this cycle, go LOAD.
- LOAD: capture {q2,q1,q0} into a 24-bit interleave register e, where e[3i+s] = qs[i], i = 0..7. Go EMIT0.
- EMITj (j = 0..2): out_data = e[8j+7 : 8j], out_valid = 1, held stable until out_ready. On handshake go EMIT(j+1). From EMIT2, increment the group counter. If the new count equals groups_total go DONE, else go WAIT.
- DONE: blk_done = 1 for one cycle, busy drops, go IDLE.
- Partial FIFO empties (any bit of empty set) stall in WAIT. No stream is ever read alone.
- start while busy is ignored. start in the same cycle as DONE is ignored; it must be re-issued in IDLE.
- Reset mid-block: immediate return to IDLE, with all outputs at reset values. The subblock FIFOs are not flushed by this block.

## Timing
- Reset values: rdreq_subblock 3'b000, out_data 8'h00, out_valid 0, busy 0, blk_done 0, err_timeout 0. State IDLE, counters 0.
- All outputs are registered except rdreq_subblock, which is decoded from state READ.
- FIFOs are non-show-ahead: q is valid in the cycle after rdreq and is sampled at the end of LOAD.
- Minimum group period is 6 cycles (WAIT, READ, LOAD, EMIT0–2) with empty = 0 and out_ready = 1.
- First out_valid appears 4 cycles after start when the FIFOs are already non-empty: start, WAIT, READ, LOAD, EMIT0.
- Block time with no stalls: 6·K/8 + 2 cycles, i.e. 794 for K_SMALL and 4610 for K_LARGE.
- out_valid is never withdrawn without a handshake, except by reset or watchdog abort.

## Configuration
- CONVDRAIN_WDOG_EN defined:
  - A 16-bit stall counter increments on each cycle spent in WAIT with empty != 0, or in EMITj with out_ready = 0.
  - The counter clears on any state change.
  - On reaching TIMEOUT: pulse err_timeout for one cycle, drop out_valid, return to IDLE with no blk_done.
- CONVDRAIN_WDOG_EN undefined: no stall counter is built, err_timeout is tied 0, and stalls are unbounded.

## Test plan
- Single group pattern: K_SMALL, q0=8'hFF, q1=8'h00, q2=8'h00 for every group -> each group emits 8'h49, 8'h92, 8'h24. blk_done pulses after byte 396; 132 rdreq pulses total.
- Large block, all-ones streams, out_ready=1 -> 2304 bytes of 8'hFF, 768 rdreq pulses, blk_done 4610 cycles after start.
- Backpressure: out_ready toggled 1/0 each cycle -> out_data stable while out_valid & !out_ready, no byte lost or duplicated (compare against model).
- Staggered empties: empty=3'b010 for 20 cycles mid-block -> rdreq stays 000 throughout, then resumes 111; output matches model.
- Reset in EMIT1 of group 5 -> next cycle all outputs at reset values. A new start drains a fresh block correctly.
- Watchdog (CONVDRAIN_WDOG_EN, TIMEOUT=16): empty held 3'b001 in WAIT -> err_timeout pulses on the 16th stall cycle, busy falls, no blk_done.
